// File: rtl/gw_flux_stream_encoder.sv
// Greaseweazle flux-stream encoder: absolute flux/index timestamps in, variable-length byte stream out.
// Optional statistics counters are enabled by defining GW_FLUX_STATS_EN.
module gw_flux_stream_encoder #(
  parameter int unsigned TS_W       = 28,
  parameter int unsigned FIFO_DEPTH = 32,
  parameter int unsigned FIFO_AW    = 5
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              stop,
  input  logic [31:0]       in_data,
  input  logic              in_valid,
  output logic              in_ready,
  output logic [7:0]        out_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              busy,
  output logic              done,
  output logic [FIFO_AW:0]  fifo_level
`ifdef GW_FLUX_STATS_EN
  ,
  output logic [31:0]       stat_flux,
  output logic [15:0]       stat_index,
  output logic [15:0]       stat_space,
  output logic [15:0]       stat_zero
`endif
);

  typedef enum logic [2:0] {S_IDLE, S_BASE, S_RUN, S_EMIT, S_TERM, S_DONE} state_e;

  localparam int unsigned          SpaceMax = FIFO_DEPTH - 7;
  localparam logic [FIFO_AW-1:0]   PtrOne   = 1;
  localparam logic [FIFO_AW:0]     LvlOne   = 1;

  state_e            state_q, state_d;
  logic [TS_W-1:0]   base_q, base_d;
  logic [6:0][7:0]   stage_q, stage_d;
  logic [2:0]        cnt_q, cnt_d, idx_q, idx_d;
  logic              stop_q, stop_d;
  logic              done_q;

  // Byte FIFO (first-word-fall-through)
  logic [7:0]         mem [FIFO_DEPTH];
  logic [FIFO_AW-1:0] wr_ptr_q, rd_ptr_q;
  logic [FIFO_AW:0]   level_q;
  logic               push, pop, full, can_push, space_ok;
  logic [7:0]         push_data;

  assign out_valid  = (level_q != '0);
  assign out_data   = out_valid ? mem[rd_ptr_q] : 8'h00;
  assign pop        = out_valid && out_ready;
  assign full       = (32'(level_q) == FIFO_DEPTH);
  assign can_push   = !full || pop;
  assign space_ok   = (32'(level_q) <= SpaceMax);
  assign fifo_level = level_q;

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr_q] <= push_data;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + PtrOne;
      if (pop)  rd_ptr_q <= rd_ptr_q + PtrOne;
      case ({push, pop})
        2'b10:   level_q <= level_q + LvlOne;
        2'b01:   level_q <= level_q - LvlOne;
        default: level_q <= level_q;
      endcase
    end
  end

  // Word decode and staging-byte generation
  logic [TS_W-1:0] ts, delta;
  logic [27:0]     d28, n_space;
  logic            is_index;
  logic [10:0]     e, off;
  logic [2:0]      q;
  logic [6:0][7:0] enc_stage;
  logic [2:0]      enc_cnt;
  logic            unused_bits;

  assign ts          = in_data[TS_W-1:0];
  assign is_index    = in_data[31];
  assign delta       = ts - base_q;
  assign d28         = 28'(delta);
  assign n_space     = d28 - 28'd249;
  assign unused_bits = ^in_data[30:TS_W];

  function automatic logic [3:0][7:0] n28(input logic [27:0] n);
    logic [3:0][7:0] b;
    b[0] = {n[6:0],   1'b1};
    b[1] = {n[13:7],  1'b1};
    b[2] = {n[20:14], 1'b1};
    b[3] = {n[27:21], 1'b1};
    return b;
  endfunction

  // Quotient/remainder of (d-250)/255 for d < 1525 via a compare ladder
  always_comb begin
    e = d28[10:0] - 11'd250;
    if (e >= 11'd1020)     begin q = 3'd4; off = 11'd1020; end
    else if (e >= 11'd765) begin q = 3'd3; off = 11'd765;  end
    else if (e >= 11'd510) begin q = 3'd2; off = 11'd510;  end
    else if (e >= 11'd255) begin q = 3'd1; off = 11'd255;  end
    else                   begin q = 3'd0; off = 11'd0;    end
  end

  always_comb begin
    logic [3:0][7:0] nb;
    enc_stage = '0;
    enc_cnt   = 3'd0;
    nb        = n28(is_index ? d28 : n_space);
    if (is_index) begin
      enc_stage[0] = 8'hFF;
      enc_stage[1] = 8'h01;
      enc_stage[2] = nb[0];
      enc_stage[3] = nb[1];
      enc_stage[4] = nb[2];
      enc_stage[5] = nb[3];
      enc_cnt      = 3'd6;
    end else if (d28 == 28'd0) begin
      enc_cnt = 3'd0;
    end else if (d28 < 28'd250) begin
      enc_stage[0] = d28[7:0];
      enc_cnt      = 3'd1;
    end else if (d28 < 28'd1525) begin
      enc_stage[0] = 8'd250 + {5'd0, q};
      enc_stage[1] = 8'(e - off) + 8'd1;
      enc_cnt      = 3'd2;
    end else begin
      enc_stage[0] = 8'hFF;
      enc_stage[1] = 8'h02;
      enc_stage[2] = nb[0];
      enc_stage[3] = nb[1];
      enc_stage[4] = nb[2];
      enc_stage[5] = nb[3];
      enc_stage[6] = 8'hF9;
      enc_cnt      = 3'd7;
    end
  end

  assign busy = (state_q != S_IDLE) && (state_q != S_DONE);
  assign done = done_q;

  always_comb begin
    state_d   = state_q;
    base_d    = base_q;
    stage_d   = stage_q;
    cnt_d     = cnt_q;
    idx_d     = idx_q;
    stop_d    = stop_q | (stop && busy);
    push      = 1'b0;
    push_data = stage_q[idx_q];
    in_ready  = 1'b0;
    case (state_q)
      S_IDLE, S_DONE: begin
        if (start) begin
          state_d = S_BASE;
          stop_d  = 1'b0;
        end
      end
      S_BASE: begin
        in_ready = !stop_q;
        if (stop_q) begin
          state_d = S_TERM;
        end else if (in_valid && !is_index) begin
          base_d  = ts;
          state_d = S_RUN;
        end
      end
      S_RUN: begin
        in_ready = !stop_q && space_ok;
        if (stop_q) begin
          state_d = S_TERM;
        end else if (in_valid && in_ready) begin
          stage_d = enc_stage;
          cnt_d   = enc_cnt;
          idx_d   = 3'd0;
          if (!is_index) base_d = ts;
          state_d = (enc_cnt == 3'd0) ? S_RUN : S_EMIT;
        end
      end
      S_EMIT: begin
        if (can_push) begin
          push = 1'b1;
          if (idx_q == 3'(cnt_q - 3'd1)) state_d = stop_q ? S_TERM : S_RUN;
          else                           idx_d   = idx_q + 3'd1;
        end
      end
      S_TERM: begin
        push_data = 8'h00;
        if (can_push) begin
          push    = 1'b1;
          state_d = S_DONE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      base_q  <= '0;
      stage_q <= '0;
      cnt_q   <= '0;
      idx_q   <= '0;
      stop_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      base_q  <= base_d;
      stage_q <= stage_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      stop_q  <= stop_d;
      // 0x00 only ever appears as the terminator in this byte stream
      done_q  <= pop && (out_data == 8'h00);
    end
  end

`ifdef GW_FLUX_STATS_EN
  logic start_acc, run_acc;
  assign start_acc = ((state_q == S_IDLE) || (state_q == S_DONE)) && start;
  assign run_acc   = (state_q == S_RUN) && in_valid && in_ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stat_flux  <= '0;
      stat_index <= '0;
      stat_space <= '0;
      stat_zero  <= '0;
    end else if (start_acc) begin
      stat_flux  <= '0;
      stat_index <= '0;
      stat_space <= '0;
      stat_zero  <= '0;
    end else if (run_acc) begin
      if (is_index) begin
        if (stat_index != '1) stat_index <= stat_index + 16'd1;
      end else if (enc_cnt == 3'd0) begin
        if (stat_zero != '1) stat_zero <= stat_zero + 16'd1;
      end else begin
        if (stat_flux != '1) stat_flux <= stat_flux + 32'd1;
        if (enc_cnt == 3'd7 && stat_space != '1) stat_space <= stat_space + 16'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_gw_flux_stream_encoder.sv
// Scoreboard bench for gw_flux_stream_encoder: an independent arithmetic model queues expected bytes.
module tb_gw_flux_stream_encoder;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic        stop = 1'b0;
  logic [31:0] in_data = '0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [7:0]  out_data;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic        busy;
  logic        done;
  logic [5:0]  fifo_level;

  int total = 0;
  int bad = 0;
  int done_cnt = 0;
  logic [7:0]  exp_q[$];
  logic [7:0]  obs_q[$];
  logic [27:0] m_base;

  gw_flux_stream_encoder #(.TS_W(28), .FIFO_DEPTH(32), .FIFO_AW(5)) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .stop       (stop),
    .in_data    (in_data),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .out_data   (out_data),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .busy       (busy),
    .done       (done),
    .fifo_level (fifo_level)
  );

  always #5 clk = ~clk;

  // A byte seen valid+ready here is popped on the following rising edge.
  always @(negedge clk) begin
    if (out_valid && out_ready) obs_q.push_back(out_data);
    if (done) done_cnt++;
  end

  initial begin
    #3000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic push_n28(input logic [27:0] n);
    int unsigned v = 32'(n);
    exp_q.push_back(8'(((v << 1) & 32'hFF) | 32'h1));
    exp_q.push_back(8'(((v >> 6) & 32'hFE) | 32'h1));
    exp_q.push_back(8'(((v >> 13) & 32'hFE) | 32'h1));
    exp_q.push_back(8'(((v >> 20) & 32'hFE) | 32'h1));
  endtask

  task automatic model_flux(input logic [27:0] ts);
    logic [27:0] dd = ts - m_base;
    int unsigned d = 32'(dd);
    if (d == 0) begin
    end else if (d < 250) begin
      exp_q.push_back(8'(d));
    end else if (d < 1525) begin
      exp_q.push_back(8'(250 + (d - 250) / 255));
      exp_q.push_back(8'(1 + (d - 250) % 255));
    end else begin
      exp_q.push_back(8'hFF);
      exp_q.push_back(8'h02);
      push_n28(28'(d - 249));
      exp_q.push_back(8'hF9);
    end
    m_base = ts;
  endtask

  task automatic send(input logic idx, input logic [27:0] ts);
    int n = 0;
    in_data  = {idx, 3'b000, ts};
    in_valid = 1'b1;
    @(negedge clk);
    while (!in_ready && n < 400) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready) begin
      total++;
      bad++;
      $display("FAIL send_timeout: in_ready=%0b required=1 ts=%h", in_ready, ts);
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic flux(input logic [27:0] ts);
    model_flux(ts);
    send(1'b0, ts);
  endtask

  task automatic index_word(input logic [27:0] ts);
    exp_q.push_back(8'hFF);
    exp_q.push_back(8'h01);
    push_n28(ts - m_base);
    send(1'b1, ts);
  endtask

  task automatic base_word(input logic [27:0] ts);
    m_base = ts;
    send(1'b0, ts);
  endtask

  task automatic start_stream();
    done_cnt = 0;
    @(posedge clk);
    #1 start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    total++;
    if (busy !== 1'b1) begin
      bad++;
      $display("FAIL start_busy: busy=%0b required=1", busy);
    end
  endtask

  task automatic stop_stream();
    exp_q.push_back(8'h00);
    @(posedge clk);
    #1 stop = 1'b1;
    @(posedge clk);
    #1 stop = 1'b0;
  endtask

  task automatic wait_drain();
    int n = 0;
    out_ready = 1'b1;
    while (obs_q.size() < exp_q.size() && n < 600) begin
      @(negedge clk);
      n++;
    end
    repeat (6) @(negedge clk);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    total += 6;
    if (in_ready !== 1'b0) begin bad++; $display("FAIL rst_in_ready: got=%0b req=0", in_ready); end
    if (out_valid !== 1'b0) begin bad++; $display("FAIL rst_out_valid: got=%0b req=0", out_valid); end
    if (out_data !== 8'h00) begin bad++; $display("FAIL rst_out_data: got=%h req=00", out_data); end
    if (busy !== 1'b0) begin bad++; $display("FAIL rst_busy: got=%0b req=0", busy); end
    if (done !== 1'b0) begin bad++; $display("FAIL rst_done: got=%0b req=0", done); end
    if (fifo_level !== 6'd0) begin bad++; $display("FAIL rst_level: got=%0d req=0", fifo_level); end
    rst = 1'b0;
    @(posedge clk);
    #1;
  endtask

  task automatic test_direct();
    logic [7:0] e, o;
    start_stream();
    base_word(28'd1000);
    flux(28'd1100);
    flux(28'd1349);
    stop_stream();
    wait_drain();
    total++;
    if (obs_q.size() !== exp_q.size()) begin
      bad++;
      $display("FAIL direct_count: got=%0d req=%0d", obs_q.size(), exp_q.size());
    end
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      e = exp_q.pop_front();
      o = obs_q.pop_front();
      total++;
      if (o !== e) begin bad++; $display("FAIL direct_byte: got=%h req=%h", o, e); end
    end
    total += 2;
    if (done_cnt !== 1) begin bad++; $display("FAIL direct_done: pulses=%0d req=1", done_cnt); end
    if (busy !== 1'b0) begin bad++; $display("FAIL direct_busy: got=%0b req=0", busy); end
    exp_q.delete();
    obs_q.delete();
  endtask

  task automatic test_two_byte();
    logic [7:0] e, o;
    start_stream();
    base_word(28'd1000);
    flux(28'd1300);
    flux(28'd2824);
    flux(28'd3074);
    stop_stream();
    wait_drain();
    total++;
    if (obs_q.size() !== exp_q.size()) begin
      bad++;
      $display("FAIL two_byte_count: got=%0d req=%0d", obs_q.size(), exp_q.size());
    end
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      e = exp_q.pop_front();
      o = obs_q.pop_front();
      total++;
      if (o !== e) begin bad++; $display("FAIL two_byte_byte: got=%h req=%h", o, e); end
    end
    exp_q.delete();
    obs_q.delete();
  endtask

  task automatic test_space();
    logic [7:0] e, o;
    start_stream();
    base_word(28'd0);
    flux(28'd2000);
    flux(28'd3525);
    stop_stream();
    wait_drain();
    total++;
    if (obs_q.size() !== exp_q.size()) begin
      bad++;
      $display("FAIL space_count: got=%0d req=%0d", obs_q.size(), exp_q.size());
    end
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      e = exp_q.pop_front();
      o = obs_q.pop_front();
      total++;
      if (o !== e) begin bad++; $display("FAIL space_byte: got=%h req=%h", o, e); end
    end
    exp_q.delete();
    obs_q.delete();
  endtask

  task automatic test_wrap_index();
    logic [7:0] e, o;
    start_stream();
    send(1'b1, 28'h0000123);
    base_word(28'hFFFFFF0);
    flux(28'h0000010);
    index_word(28'h0000042);
    flux(28'h0000074);
    flux(28'h0000074);
    stop_stream();
    wait_drain();
    total++;
    if (obs_q.size() !== exp_q.size()) begin
      bad++;
      $display("FAIL wrap_count: got=%0d req=%0d", obs_q.size(), exp_q.size());
    end
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      e = exp_q.pop_front();
      o = obs_q.pop_front();
      total++;
      if (o !== e) begin bad++; $display("FAIL wrap_byte: got=%h req=%h", o, e); end
    end
    exp_q.delete();
    obs_q.delete();
  endtask

  task automatic test_back_pressure();
    logic [7:0]  e, o;
    logic [27:0] t;
    out_ready = 1'b0;
    start_stream();
    t = 28'd5000;
    base_word(t);
    for (int i = 0; i < 25; i++) begin
      t = t + 28'd100;
      flux(t);
    end
    flux(t + 28'd2000);
    repeat (12) @(negedge clk);
    total += 3;
    if (fifo_level !== 6'd32) begin bad++; $display("FAIL bp_level: got=%0d req=32", fifo_level); end
    if (in_ready !== 1'b0) begin bad++; $display("FAIL bp_in_ready: got=%0b req=0", in_ready); end
    if (obs_q.size() !== 0) begin bad++; $display("FAIL bp_early: got=%0d req=0", obs_q.size()); end
    stop_stream();
    wait_drain();
    total++;
    if (obs_q.size() !== exp_q.size()) begin
      bad++;
      $display("FAIL bp_count: got=%0d req=%0d", obs_q.size(), exp_q.size());
    end
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      e = exp_q.pop_front();
      o = obs_q.pop_front();
      total++;
      if (o !== e) begin bad++; $display("FAIL bp_byte: got=%h req=%h", o, e); end
    end
    exp_q.delete();
    obs_q.delete();
  endtask

  task automatic test_reset_mid();
    logic [7:0] e, o;
    start_stream();
    base_word(28'd0);
    flux(28'd2000);
    @(posedge clk);
    #1;
    @(posedge clk);
    #1;
    rst = 1'b1;
    #1;
    total += 4;
    if (fifo_level !== 6'd0) begin bad++; $display("FAIL mid_level: got=%0d req=0", fifo_level); end
    if (out_valid !== 1'b0) begin bad++; $display("FAIL mid_out_valid: got=%0b req=0", out_valid); end
    if (busy !== 1'b0) begin bad++; $display("FAIL mid_busy: got=%0b req=0", busy); end
    if (in_ready !== 1'b0) begin bad++; $display("FAIL mid_in_ready: got=%0b req=0", in_ready); end
    exp_q.delete();
    obs_q.delete();
    @(posedge clk);
    #1 rst = 1'b0;
    repeat (4) @(negedge clk);
    total++;
    if (obs_q.size() !== 0) begin bad++; $display("FAIL mid_residue: got=%0d req=0", obs_q.size()); end
    start_stream();
    base_word(28'd10);
    flux(28'd110);
    flux(28'd2010);
    stop_stream();
    wait_drain();
    total++;
    if (obs_q.size() !== exp_q.size()) begin
      bad++;
      $display("FAIL mid_count: got=%0d req=%0d", obs_q.size(), exp_q.size());
    end
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      e = exp_q.pop_front();
      o = obs_q.pop_front();
      total++;
      if (o !== e) begin bad++; $display("FAIL mid_byte: got=%h req=%h", o, e); end
    end
    total++;
    if (done_cnt !== 1) begin bad++; $display("FAIL mid_done: pulses=%0d req=1", done_cnt); end
    exp_q.delete();
    obs_q.delete();
  endtask

  initial begin
    test_reset();
    test_direct();
    test_two_byte();
    test_space();
    test_wrap_index();
    test_back_pressure();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
